// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 style sequencer:
// states, opcodes, mux selects and the control bundle.
package lc3_pkg;

  typedef enum logic [3:0] {
    S_HALTED = 4'd0,
    S_F1     = 4'd1,
    S_F2     = 4'd2,
    S_F3     = 4'd3,
    S_DEC    = 4'd4,
    S_ALU    = 4'd5,
    S_BR     = 4'd6,
    S_JMP    = 4'd7,
    S_LDR1   = 4'd8,
    S_LDR2   = 4'd9,
    S_LDR3   = 4'd10,
    S_STR1   = 4'd11,
    S_STR2   = 4'd12,
    S_STR3   = 4'd13,
    S_PAUSE  = 4'd14,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       sr2mux;
    logic       mem_req;
    logic       mem_we;
    logic       fault;
  } ctrl_t;

  function automatic logic [1:0] aluk_of(input logic [3:0] op);
    unique case (1'b1)
      op == OP_AND: aluk_of = ALUK_AND;
      op == OP_NOT: aluk_of = ALUK_NOT;
      default:      aluk_of = ALUK_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; flags the cycle in
// which the count would reach LIMIT.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [7:0] count;

  // count waiting cycles, zero outside wait states
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    count <= 8'd0;
    else if (clear)  count <= 8'd0;
    else if (enable) count <= count + 8'd1;
  end

  assign timeout = enable && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/instr_seq_ctrl.sv
// LC-3 style instruction sequencer: fetch, decode,
// execute control with memory-wait timeout fault.
module instr_seq_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  input  logic       Mem_Rdy,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       SR2MUX,
  output logic       Mem_Req,
  output logic       Mem_WE,
  output logic       Fault
);

  state_t state, next;
  logic   cont_seen;
  logic   wait_st;
  logic   tmo;
  ctrl_t  c;

  assign wait_st = (state == S_F2) ||
                   (state == S_LDR2) ||
                   (state == S_STR3);

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (!wait_st),
    .enable  (wait_st && !Mem_Rdy),
    .timeout (tmo)
  );

  // state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_HALTED;
    else          state <= next;
  end

  // PAUSE needs Continue low once after entry
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)               cont_seen <= 1'b0;
    else if (state != S_PAUSE)  cont_seen <= 1'b0;
    else if (!Continue)         cont_seen <= 1'b1;
  end

  // next-state selection
  always_comb begin
    next = state;
    unique case (state)
      S_HALTED: if (Run) next = S_F1;
      S_F1:     next = S_F2;
      S_F2: begin
        if (Mem_Rdy)  next = S_F3;
        else if (tmo) next = S_FAULT;
      end
      S_F3:     next = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          Opcode == OP_ADD,
          Opcode == OP_AND,
          Opcode == OP_NOT:   next = S_ALU;
          Opcode == OP_BR:    next = S_BR;
          Opcode == OP_JMP:   next = S_JMP;
          Opcode == OP_LDR:   next = S_LDR1;
          Opcode == OP_STR:   next = S_STR1;
          Opcode == OP_PAUSE: next = S_PAUSE;
          default:            next = S_F1;
        endcase
      end
      S_ALU:    next = S_F1;
      S_BR:     next = S_F1;
      S_JMP:    next = S_F1;
      S_LDR1:   next = S_LDR2;
      S_LDR2: begin
        if (Mem_Rdy)  next = S_LDR3;
        else if (tmo) next = S_FAULT;
      end
      S_LDR3:   next = S_F1;
      S_STR1:   next = S_STR2;
      S_STR2:   next = S_STR3;
      S_STR3: begin
        if (Mem_Rdy)  next = S_F1;
        else if (tmo) next = S_FAULT;
      end
      S_PAUSE:  if (cont_seen && Continue) next = S_F1;
      S_FAULT:  next = S_FAULT;
    endcase
  end

  // control word decode, Moore except MDR/PC strobes
  always_comb begin
    c = '0;
    unique case (state)
      S_HALTED: ;
      S_F1: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
        c.pcmux   = PCMUX_INC;
      end
      S_F2, S_LDR2: begin
        c.mem_req = 1'b1;
        c.ld_mdr  = Mem_Rdy;
      end
      S_F3: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      S_DEC:    c.ld_ben = 1'b1;
      S_ALU: begin
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
        c.aluk     = aluk_of(Opcode);
        c.sr2mux   = IR_5;
      end
      S_BR: begin
        c.ld_pc    = BEN;
        c.pcmux    = PCMUX_ADDER;
        c.addr1mux = 1'b0;
        c.addr2mux = A2_OFF9;
      end
      S_JMP: begin
        c.ld_pc    = 1'b1;
        c.pcmux    = PCMUX_ADDER;
        c.addr1mux = 1'b1;
        c.addr2mux = A2_ZERO;
      end
      S_LDR1, S_STR1: begin
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
        c.addr1mux    = 1'b1;
        c.addr2mux    = A2_OFF6;
      end
      S_LDR3: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S_STR2: begin
        c.gate_alu = 1'b1;
        c.aluk     = ALUK_PASS;
        c.ld_mdr   = 1'b1;
      end
      S_STR3: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
      end
      S_PAUSE:  ;
      S_FAULT:  c.fault = 1'b1;
    endcase
  end

  assign LD_MAR     = c.ld_mar;
  assign LD_MDR     = c.ld_mdr;
  assign LD_IR      = c.ld_ir;
  assign LD_BEN     = c.ld_ben;
  assign LD_CC      = c.ld_cc;
  assign LD_REG     = c.ld_reg;
  assign LD_PC      = c.ld_pc;
  assign GatePC     = c.gate_pc;
  assign GateMDR    = c.gate_mdr;
  assign GateALU    = c.gate_alu;
  assign GateMARMUX = c.gate_marmux;
  assign PCMUX      = c.pcmux;
  assign ADDR1MUX   = c.addr1mux;
  assign ADDR2MUX   = c.addr2mux;
  assign ALUK       = c.aluk;
  assign SR2MUX     = c.sr2mux;
  assign Mem_Req    = c.mem_req;
  assign Mem_WE     = c.mem_we;
  assign Fault      = c.fault;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed scoreboard bench for instr_seq_ctrl:
// per-cycle expected control words, popped at negedge.
module tb_instr_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Run = 1'b0;
  logic       Continue = 1'b0;
  logic [3:0] Opcode = 4'h0;
  logic       IR_5 = 1'b0;
  logic       BEN = 1'b0;
  logic       Mem_Rdy = 1'b0;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN;
  logic       LD_CC, LD_REG, LD_PC;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       ADDR1MUX, SR2MUX;
  logic       Mem_Req, Mem_WE, Fault;

  instr_seq_ctrl #(.MEM_TIMEOUT(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run),
    .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN), .Mem_Rdy(Mem_Rdy),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
    .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG),
    .LD_PC(LD_PC), .GatePC(GatePC), .GateMDR(GateMDR),
    .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .SR2MUX(SR2MUX),
    .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  // Word layout, MSB first:
  // LD_MAR LD_MDR LD_IR LD_BEN LD_CC LD_REG LD_PC
  // GatePC GateMDR GateALU GateMARMUX PCMUX[2]
  // ADDR1MUX ADDR2MUX[2] ALUK[2] SR2MUX Mem_Req Mem_WE Fault
  localparam logic [21:0] W_ZERO  = 22'h000000;
  localparam logic [21:0] W_F1    = 22'h20C000;
  localparam logic [21:0] W_F2    = 22'h000004;
  localparam logic [21:0] W_F2R   = 22'h100004;
  localparam logic [21:0] W_F3    = 22'h082000;
  localparam logic [21:0] W_DEC   = 22'h040000;
  localparam logic [21:0] W_ADD0  = 22'h031000;
  localparam logic [21:0] W_AND1  = 22'h031018;
  localparam logic [21:0] W_NOT0  = 22'h031020;
  localparam logic [21:0] W_BR1   = 22'h008480;
  localparam logic [21:0] W_BR0   = 22'h000480;
  localparam logic [21:0] W_JMP   = 22'h008500;
  localparam logic [21:0] W_ADR   = 22'h200940;
  localparam logic [21:0] W_LDR3  = 22'h032000;
  localparam logic [21:0] W_STR2  = 22'h101030;
  localparam logic [21:0] W_STR3  = 22'h000006;
  localparam logic [21:0] W_FAULT = 22'h000001;

  logic [21:0] exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [21:0] got;

  assign got = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC,
                LD_REG, LD_PC, GatePC, GateMDR, GateALU,
                GateMARMUX, PCMUX, ADDR1MUX, ADDR2MUX,
                ALUK, SR2MUX, Mem_Req, Mem_WE, Fault};

  // monitor: compare the oldest expectation each cycle
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", t, got, e);
      end
    end
  end

  task automatic cyc(input logic rn, input logic run,
                     input logic cont, input logic rdy,
                     input logic ben, input logic [3:0] op,
                     input logic i5, input logic [21:0] ew,
                     input string tag);
    @(posedge Clk);
    #1;
    Reset_n  = rn;
    Run      = run;
    Continue = cont;
    Mem_Rdy  = rdy;
    BEN      = ben;
    Opcode   = op;
    IR_5     = i5;
    exp_q.push_back(ew);
    tag_q.push_back(tag);
  endtask

  // F1, one-cycle F2, F3, DEC for opcode op
  task automatic fetch(input logic [3:0] op, input logic i5,
                       input logic ben, input logic cont);
    cyc(1, 0, cont, 0, ben, op, i5, W_F1, "f1");
    cyc(1, 0, cont, 1, ben, op, i5, W_F2R, "f2rdy");
    cyc(1, 0, cont, 0, ben, op, i5, W_F3, "f3");
    cyc(1, 0, cont, 1, ben, op, i5, W_DEC, "dec");
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 4'h0, 0, W_ZERO, "reset");
    cyc(0, 1, 0, 1, 0, 4'h0, 0, W_ZERO, "reset_run");
    // IR=0x1042, ready two cycles after request
    cyc(1, 1, 0, 0, 0, 4'h1, 0, W_ZERO, "halted_run");
    cyc(1, 0, 0, 0, 0, 4'h1, 0, W_F1, "f1_rundrop");
    cyc(1, 0, 0, 0, 0, 4'h1, 0, W_F2, "f2_wait");
    cyc(1, 0, 0, 1, 0, 4'h1, 0, W_F2R, "f2_rdy");
    cyc(1, 0, 0, 0, 0, 4'h1, 0, W_F3, "f3");
    cyc(1, 0, 0, 0, 0, 4'h1, 0, W_DEC, "dec");
    cyc(1, 0, 0, 0, 0, 4'h1, 0, W_ADD0, "alu_add");
    fetch(4'h5, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 4'h5, 1, W_AND1, "alu_and_imm");
    fetch(4'h9, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 4'h9, 0, W_NOT0, "alu_not");
    // IR=0x0E05 taken and not taken
    fetch(4'h0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 4'h0, 0, W_BR1, "br_taken");
    fetch(4'h0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 4'h0, 0, W_BR0, "br_not_taken");
    fetch(4'hC, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 4'hC, 0, W_JMP, "jmp");
    fetch(4'h6, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 4'h6, 0, W_ADR, "ldr1_rdy_ign");
    cyc(1, 0, 0, 0, 0, 4'h6, 0, W_F2, "ldr2_wait");
    cyc(1, 0, 0, 1, 0, 4'h6, 0, W_F2R, "ldr2_rdy");
    cyc(1, 0, 0, 0, 0, 4'h6, 0, W_LDR3, "ldr3");
    fetch(4'hF, 0, 0, 0);
    // IR=0xD000 with Continue held high on entry
    fetch(4'hD, 0, 0, 1);
    cyc(1, 0, 1, 0, 0, 4'hD, 0, W_ZERO, "pause_held1");
    cyc(1, 0, 1, 0, 0, 4'hD, 0, W_ZERO, "pause_held2");
    cyc(1, 0, 0, 0, 0, 4'hD, 0, W_ZERO, "pause_low");
    cyc(1, 0, 1, 0, 0, 4'hD, 0, W_ZERO, "pause_rel");
    // ready on the timeout cycle wins
    cyc(1, 0, 0, 0, 0, 4'hF, 0, W_F1, "f1_after_pause");
    for (int i = 0; i < 15; i++)
      cyc(1, 0, 0, 0, 0, 4'hF, 0, W_F2, "f2_long");
    cyc(1, 0, 0, 1, 0, 4'hF, 0, W_F2R, "f2_rdy_edge");
    cyc(1, 0, 0, 0, 0, 4'hF, 0, W_F3, "f3_no_fault");
    cyc(1, 0, 0, 0, 0, 4'hF, 0, W_DEC, "dec_nop");
    // store, normal completion
    fetch(4'h7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 4'h7, 0, W_ADR, "str1");
    cyc(1, 0, 0, 0, 0, 4'h7, 0, W_STR2, "str2");
    cyc(1, 0, 0, 0, 0, 4'h7, 0, W_STR3, "str3_wait");
    cyc(1, 0, 0, 1, 0, 4'h7, 0, W_STR3, "str3_rdy");
    // store, reset during the write wait
    fetch(4'h7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 4'h7, 0, W_ADR, "str1b");
    cyc(1, 0, 0, 0, 0, 4'h7, 0, W_STR2, "str2b");
    cyc(1, 0, 0, 0, 0, 4'h7, 0, W_STR3, "str3b_wait");
    cyc(0, 0, 0, 0, 0, 4'h7, 0, W_ZERO, "str3_async_rst");
    cyc(1, 0, 0, 0, 0, 4'h7, 0, W_ZERO, "halted_after");
    cyc(1, 0, 0, 0, 0, 4'h7, 0, W_ZERO, "halted_norun");
    // no ready at all: fault 16 cycles after F2 entry
    cyc(1, 1, 0, 0, 0, 4'h1, 0, W_ZERO, "halted_run2");
    cyc(1, 0, 0, 0, 0, 4'h1, 0, W_F1, "f1_to");
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 0, 0, 0, 4'h1, 0, W_F2, "f2_to");
    cyc(1, 1, 1, 1, 0, 4'h1, 0, W_FAULT, "fault");
    cyc(1, 1, 1, 1, 0, 4'h1, 0, W_FAULT, "fault_sticky");
    cyc(1, 0, 0, 0, 0, 4'h1, 0, W_FAULT, "fault_sticky2");
    cyc(0, 0, 0, 0, 0, 4'h1, 0, W_ZERO, "fault_reset");
    cyc(1, 0, 0, 0, 0, 4'h1, 0, W_ZERO, "halted_final");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge Clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_seq_ctrl.md
INSTR_SEQ_CTRL -- requirements
Module: instr_seq_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max wait cycles for Mem_Rdy before fault; legal range 2..255.
REQ-002 Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Run  in  1  level; starts sequencing from HALTED.
REQ-005 Continue  in  1  level; releases PAUSE.
REQ-006 Opcode  in  4  IR[15:12] as registered by the datapath.
REQ-007 IR_5  in  1  IR[5], immediate select for ADD/AND.
REQ-008 BEN  in  1  registered branch-enable from the branch-condition unit.
REQ-009 Mem_Rdy  in  1  memory completion strobe, one cycle.
REQ-010 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  out  1 each  register load enables.
REQ-011 GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle.
REQ-012 PCMUX  out  2  00 PC+1, 01 bus, 10 adder.
REQ-013 ADDR1MUX  out  1  0 PC, 1 SR1; ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11.
REQ-014 ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS; SR2MUX  out  1  equals IR_5 in ALU states.
REQ-015 Mem_Req, Mem_WE  out  1 each  memory request and write qualifier.
REQ-016 Fault  out  1  sticky memory-timeout flag.

Function
REQ-017 States SHALL be: HALTED, F1, F2, F3, DEC, ALU, BR, JMP, LDR1, LDR2, LDR3, STR1, STR2, STR3, PAUSE, FAULT.
REQ-018 Every output not asserted by a state SHALL be 0; mux selects default 00/0.
REQ-019 HALTED: all outputs 0; Run=1 -> F1 next cycle.
REQ-020 F1: GatePC, LD_MAR, LD_PC, PCMUX=00 -> F2.
REQ-021 F2: Mem_Req=1, Mem_WE=0, LD_MDR=Mem_Rdy; Mem_Rdy -> F3; else stay.
REQ-022 F3: GateMDR, LD_IR -> DEC.
REQ-023 DEC: LD_BEN=1; next by Opcode: 0001/0101/1001 -> ALU, 0000 -> BR, 1100 -> JMP, 0110 -> LDR1, 0111 -> STR1, 1101 -> PAUSE, others -> F1 (NOP).
REQ-024 ALU: GateALU, LD_REG, LD_CC, ALUK from opcode (0001->00, 0101->01, 1001->10), SR2MUX=IR_5 -> F1.
REQ-025 BR: BEN sampled here (loaded in DEC, valid one cycle later); BEN=1 -> LD_PC, PCMUX=10, ADDR1MUX=0, ADDR2MUX=10; BEN=0 -> no load; -> F1 either way.
REQ-026 JMP: LD_PC, PCMUX=10, ADDR1MUX=1, ADDR2MUX=00 -> F1.
REQ-027 LDR1: GateMARMUX, LD_MAR, ADDR1MUX=1, ADDR2MUX=01 -> LDR2; LDR2 as F2 -> LDR3; LDR3: GateMDR, LD_REG, LD_CC -> F1.
REQ-028 STR1: as LDR1 -> STR2; STR2: GateALU, ALUK=11, LD_MDR -> STR3; STR3: Mem_Req, Mem_WE, wait Mem_Rdy -> F1.
REQ-029 PAUSE: outputs 0; Continue=1 -> F1; Continue held high across re-entry SHALL not skip a later PAUSE (requires Continue low seen once after entry).
REQ-030 Wait counter: 8-bit, cleared on entry to F2/LDR2/STR3, increments each waiting cycle; reaching MEM_TIMEOUT without Mem_Rdy -> FAULT.
REQ-031 Mem_Rdy in the same cycle the counter reaches MEM_TIMEOUT SHALL win (normal advance).
REQ-032 FAULT: Fault=1, all else 0; exits only via reset.
REQ-033 Run deasserted mid-instruction SHALL be ignored; Run only checked in HALTED.
REQ-034 Mem_Rdy outside wait states SHALL be ignored.

Reset
REQ-035 Reset_n low SHALL force HALTED, counter 0, Fault 0, all outputs 0 immediately, regardless of Clk.
REQ-036 Reset asserted mid-memory-wait SHALL drop Mem_Req/Mem_WE in the same instant.

Structure
REQ-037 State enum, opcode constants, PCMUX/ADDR2MUX/ALUK encodings SHALL live in shared package lc3_pkg.
REQ-038 Wait counter SHALL be sub-module mem_wait_timer (clear, enable, timeout out).
REQ-039 Outputs SHALL be Moore-decoded from state except LD_MDR in F2/LDR2 and LD_PC in BR.

Verification
REQ-040 Reset, Run=1, Mem_Rdy 2 cycles after Mem_Req, IR=0x1042 -> F1,F2,F2,F3,DEC,ALU; LD_REG=LD_CC=1 in ALU, SR2MUX=0.
REQ-041 IR=0x0E05 with BEN=1 in BR -> LD_PC=1, PCMUX=10, ADDR2MUX=10; repeat BEN=0 -> LD_PC=0, next F1.
REQ-042 Mem_Rdy never asserted, MEM_TIMEOUT=16 -> FAULT exactly 16 cycles after entering F2; Fault sticky until Reset_n low.
REQ-043 Mem_Rdy on timeout cycle -> F3, Fault=0.
REQ-044 IR=0xD000, Continue held 1 -> PAUSE held until Continue 0 then 1; -> F1.
REQ-045 Reset_n low mid-STR3 -> Mem_Req=Mem_WE=0 asynchronously, HALTED after release.
